// File: rtl/debug_ctrl.sv
// Debug controller for a MIPS core: accepts single-byte UART commands to step,
// run (with PC breakpoints and a cycle budget), load instruction memory and
// set breakpoints, and after each step/run streams a state-dump frame.
module debug_ctrl #(
    parameter int              NB               = 32,
    parameter int              DATA_BITS        = 8,
    parameter int              NUMBER_REGISTERS = 32,
    parameter int              NUMBER_MEM_WORDS = 16,
    parameter int              NUM_BREAKPOINTS  = 4,
    parameter int              MAX_CYCLES       = 450000,
    parameter logic [NB-1:0]   HALT_INSTRUCTION = '1
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_uart_rx_ready,
    input  logic [DATA_BITS-1:0]                i_uart_rx_data,
    input  logic                                i_uart_tx_done,
    input  logic [NB-1:0]                       i_mips_pc,
    input  logic [NB-1:0]                       i_mips_register,
    input  logic [NB-1:0]                       i_mips_mem_data,
    input  logic [NB-1:0]                       i_mips_alu_result,
    input  logic                                i_mips_wb_halt,
    output logic [$clog2(NUMBER_REGISTERS)-1:0] o_mips_register_number,
    output logic [NB-1:0]                       o_mips_memory_address,
    output logic [DATA_BITS-1:0]                o_uart_tx_data,
    output logic                                o_uart_tx_ready,
    output logic                                o_uart_rx_reset,
    output logic                                o_step,
    output logic                                o_instruction_write_enable,
    output logic [NB-1:0]                       o_instruction_address,
    output logic [NB-1:0]                       o_instruction_data,
    output logic [2:0]                          o_status,
    output logic [3:0]                          o_state_debug
);

    localparam int BPW = NB / DATA_BITS;
    localparam int RW  = $clog2(NUMBER_REGISTERS);
    localparam int PW  = (NUM_BREAKPOINTS > 1) ? $clog2(NUM_BREAKPOINTS) : 1;
    localparam int BCW = $clog2(BPW + 1);

    // Frame item indices: header, PC, registers, ALU, memory words, counter, trailer
    localparam int IT_REG0_I  = 2;
    localparam int IT_ALU_I   = IT_REG0_I + NUMBER_REGISTERS;
    localparam int IT_MEM0_I  = IT_ALU_I + 1;
    localparam int IT_CNT_I   = IT_MEM0_I + NUMBER_MEM_WORDS;
    localparam int IT_TRAIL_I = IT_CNT_I + 1;
    localparam int IW         = $clog2(IT_TRAIL_I + 1);

    localparam logic [IW-1:0] IT_HDR   = IW'(0);
    localparam logic [IW-1:0] IT_PC    = IW'(1);
    localparam logic [IW-1:0] IT_REG0  = IW'(IT_REG0_I);
    localparam logic [IW-1:0] IT_ALU   = IW'(IT_ALU_I);
    localparam logic [IW-1:0] IT_MEM0  = IW'(IT_MEM0_I);
    localparam logic [IW-1:0] IT_CNT   = IW'(IT_CNT_I);
    localparam logic [IW-1:0] IT_TRAIL = IW'(IT_TRAIL_I);

    localparam logic [DATA_BITS-1:0] CMD_STEP  = DATA_BITS'(8'h73);
    localparam logic [DATA_BITS-1:0] CMD_RUN   = DATA_BITS'(8'h63);
    localparam logic [DATA_BITS-1:0] CMD_LOAD  = DATA_BITS'(8'h69);
    localparam logic [DATA_BITS-1:0] CMD_BP    = DATA_BITS'(8'h62);
    localparam logic [DATA_BITS-1:0] CMD_CLRBP = DATA_BITS'(8'h78);
    localparam logic [DATA_BITS-1:0] FRAME_HDR = DATA_BITS'(8'hA5);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_STEP    = 4'd1,
        ST_RUN     = 4'd2,
        ST_LOAD_RX = 4'd3,
        ST_LOAD_WR = 4'd4,
        ST_BP_RX   = 4'd5,
        ST_FETCH   = 4'd6,
        ST_SEND    = 4'd7,
        ST_WAIT_TX = 4'd8
    } state_t;

    state_t               state_q;
    logic                 step_q;
    logic                 first_run_q;
    logic                 halted_q;
    logic                 bp_hit_q;
    logic                 timeout_q;
    logic [31:0]          cycles_q;
    logic [NB-1:0]        bp_addr_q [NUM_BREAKPOINTS];
    logic [NUM_BREAKPOINTS-1:0] bp_valid_q;
    logic [PW-1:0]        bp_ptr_q;
    logic [NB-1:0]        bp_buf_q;
    logic [BCW-1:0]       byte_cnt_q;
    logic [IW-1:0]        item_q;
    logic                 sel_set_q;
    logic [NB-1:0]        tx_word_q;
    logic [BCW-1:0]       tx_left_q;
    logic [NB-1:0]        instr_addr_q;
    logic [NB-1:0]        instr_data_q;
    logic                 instr_we_q;
    logic                 rx_reset_q;
    logic [DATA_BITS-1:0] tx_data_q;
    logic                 tx_ready_q;
    logic [RW-1:0]        reg_num_q;
    logic [NB-1:0]        mem_addr_q;

    logic                 bp_match;
    logic                 budget_done;
    logic                 run_block;
    logic [NB-1:0]        instr_shift_d;
    logic [NB-1:0]        bp_shift_d;
    logic                 is_reg_item;
    logic                 is_mem_item;
    logic [RW-1:0]        reg_sel_d;
    logic [NB-1:0]        mem_addr_d;
    logic [NB-1:0]        frame_word_d;
    logic [BCW-1:0]       frame_bytes_d;

    // Breakpoint comparison against the live PC
    always_comb begin
        bp_match = 1'b0;
        for (int unsigned k = 0; k < NUM_BREAKPOINTS; k++) begin
            if (bp_valid_q[k] && (bp_addr_q[k] == i_mips_pc)) bp_match = 1'b1;
        end
    end

    assign budget_done   = (cycles_q >= 32'(MAX_CYCLES));
    // In RUN the stop condition must suppress the step in the same cycle it is seen
    assign run_block     = (state_q == ST_RUN) && ((!first_run_q && bp_match) || budget_done);
    assign o_step        = step_q && !halted_q && !run_block;

    assign instr_shift_d = NB'({instr_data_q, i_uart_rx_data});
    assign bp_shift_d    = NB'({bp_buf_q, i_uart_rx_data});

    // Decode the current frame item into selects and the word to transmit
    always_comb begin
        is_reg_item   = (item_q >= IT_REG0) && (item_q < IT_ALU);
        is_mem_item   = (item_q >= IT_MEM0) && (item_q < IT_CNT);
        reg_sel_d     = RW'(item_q - IT_REG0);
        mem_addr_d    = NB'(item_q - IT_MEM0) << 2;
        frame_word_d  = '0;
        frame_bytes_d = BCW'(BPW);
        if (item_q == IT_HDR) begin
            frame_word_d  = NB'(FRAME_HDR) << (NB - DATA_BITS);
            frame_bytes_d = BCW'(1);
        end else if (item_q == IT_PC) begin
            frame_word_d  = i_mips_pc;
        end else if (is_reg_item) begin
            frame_word_d  = i_mips_register;
        end else if (item_q == IT_ALU) begin
            frame_word_d  = i_mips_alu_result;
        end else if (is_mem_item) begin
            frame_word_d  = i_mips_mem_data;
        end else if (item_q == IT_CNT) begin
            frame_word_d  = NB'(cycles_q);
        end else begin
            frame_word_d  = NB'(o_status) << (NB - DATA_BITS);
            frame_bytes_d = BCW'(1);
        end
    end

    // Main controller: command decode, run control, loader, breakpoints, frame TX
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            step_q      <= 1'b0;
            first_run_q <= 1'b0;
            halted_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
            for (int unsigned k = 0; k < NUM_BREAKPOINTS; k++) bp_addr_q[k] <= '0;
            bp_valid_q  <= '0;
            bp_ptr_q    <= '0;
            bp_buf_q    <= '0;
            byte_cnt_q  <= '0;
            item_q      <= '0;
            sel_set_q   <= 1'b0;
            tx_word_q   <= '0;
            tx_left_q   <= '0;
            instr_addr_q <= '0;
            instr_data_q <= '0;
            instr_we_q  <= 1'b0;
            rx_reset_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_ready_q  <= 1'b0;
            reg_num_q   <= '0;
            mem_addr_q  <= '0;
        end else begin
            rx_reset_q <= 1'b0;
            if (o_step && (cycles_q != '1)) cycles_q <= cycles_q + 32'd1;
            if (i_mips_wb_halt) halted_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (i_uart_rx_ready) begin
                        case (i_uart_rx_data)
                            CMD_STEP: begin
                                state_q   <= ST_STEP;
                                step_q    <= 1'b1;
                                bp_hit_q  <= 1'b0;
                                timeout_q <= 1'b0;
                            end
                            CMD_RUN: begin
                                state_q     <= ST_RUN;
                                step_q      <= 1'b1;
                                first_run_q <= 1'b1;
                                bp_hit_q    <= 1'b0;
                                timeout_q   <= 1'b0;
                            end
                            CMD_LOAD: begin
                                state_q      <= ST_LOAD_RX;
                                rx_reset_q   <= 1'b1;
                                instr_addr_q <= '0;
                                instr_data_q <= '0;
                                cycles_q     <= '0;
                                halted_q     <= 1'b0;
                                bp_hit_q     <= 1'b0;
                                timeout_q    <= 1'b0;
                                byte_cnt_q   <= '0;
                            end
                            CMD_BP: begin
                                state_q    <= ST_BP_RX;
                                bp_buf_q   <= '0;
                                byte_cnt_q <= '0;
                            end
                            CMD_CLRBP: bp_valid_q <= '0;
                            default: ;
                        endcase
                    end
                end
                ST_STEP: begin
                    step_q    <= 1'b0;
                    state_q   <= ST_FETCH;
                    item_q    <= '0;
                    sel_set_q <= 1'b0;
                end
                ST_RUN: begin
                    first_run_q <= 1'b0;
                    if (halted_q || run_block) begin
                        step_q    <= 1'b0;
                        state_q   <= ST_FETCH;
                        item_q    <= '0;
                        sel_set_q <= 1'b0;
                        if (!halted_q) begin
                            if (!first_run_q && bp_match) bp_hit_q  <= 1'b1;
                            else                          timeout_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD_RX: begin
                    if (i_uart_rx_ready) begin
                        instr_data_q <= instr_shift_d;
                        if (byte_cnt_q == BCW'(BPW - 1)) begin
                            byte_cnt_q <= '0;
                            instr_we_q <= 1'b1;
                            state_q    <= ST_LOAD_WR;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_LOAD_WR: begin
                    instr_we_q   <= 1'b0;
                    instr_addr_q <= instr_addr_q + NB'(4);
                    state_q      <= (instr_data_q == HALT_INSTRUCTION) ? ST_IDLE : ST_LOAD_RX;
                end
                ST_BP_RX: begin
                    if (i_uart_rx_ready) begin
                        bp_buf_q <= bp_shift_d;
                        if (byte_cnt_q == BCW'(BPW - 1)) begin
                            byte_cnt_q           <= '0;
                            bp_addr_q[bp_ptr_q]  <= bp_shift_d;
                            bp_valid_q[bp_ptr_q] <= 1'b1;
                            bp_ptr_q <= (bp_ptr_q == PW'(NUM_BREAKPOINTS - 1)) ? '0 : bp_ptr_q + PW'(1);
                            state_q  <= ST_IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                // Two-phase fetch: drive selects first, sample the MIPS buses next cycle
                ST_FETCH: begin
                    if (!sel_set_q) begin
                        if (is_reg_item) reg_num_q  <= reg_sel_d;
                        if (is_mem_item) mem_addr_q <= mem_addr_d;
                        sel_set_q <= 1'b1;
                    end else begin
                        tx_word_q <= frame_word_d;
                        tx_left_q <= frame_bytes_d;
                        sel_set_q <= 1'b0;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_data_q  <= tx_word_q[NB-1 -: DATA_BITS];
                    tx_ready_q <= 1'b1;
                    state_q    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_uart_tx_done) begin
                        tx_ready_q <= 1'b0;
                        tx_word_q  <= tx_word_q << DATA_BITS;
                        if (tx_left_q == BCW'(1)) begin
                            if (item_q == IT_TRAIL) begin
                                reg_num_q  <= '0;
                                mem_addr_q <= '0;
                                item_q     <= '0;
                                state_q    <= ST_IDLE;
                            end else begin
                                item_q  <= item_q + IW'(1);
                                state_q <= ST_FETCH;
                            end
                        end else begin
                            tx_left_q <= tx_left_q - BCW'(1);
                            state_q   <= ST_SEND;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_mips_register_number     = reg_num_q;
    assign o_mips_memory_address      = mem_addr_q;
    assign o_uart_tx_data             = tx_data_q;
    assign o_uart_tx_ready            = tx_ready_q;
    assign o_uart_rx_reset            = rx_reset_q;
    assign o_instruction_write_enable = instr_we_q;
    assign o_instruction_address      = instr_addr_q;
    assign o_instruction_data         = instr_data_q;
    assign o_status                   = {timeout_q, bp_hit_q, halted_q};
    assign o_state_debug              = state_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Scoreboard bench for debug_ctrl: expected TX bytes and instruction writes
// are queued when a command is issued and checked as the DUT produces them.
module tb_debug_ctrl;

    localparam int MAXC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_done;
    logic        spur_done;
    logic [31:0] pc_q;
    logic [31:0] mips_reg;
    logic [31:0] mips_mem;
    logic [31:0] mips_alu;
    logic        wb_halt;
    logic [4:0]  reg_num;
    logic [31:0] mem_addr;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_reset;
    logic        step;
    logic        we;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic [2:0]  status;
    logic [3:0]  state;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned steps;
    int unsigned rxr_cnt  = 0;
    int unsigned tx_bytes = 0;
    logic [7:0]  txq [$];
    logic [63:0] wq [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_val(input logic [4:0] r);
        return {({3'b0, r} + 8'd1), 8'h5A, 8'hC3, 3'b0, r};
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {16'hD00D, a[15:0]};
    endfunction

    assign mips_reg = reg_val(reg_num);
    assign mips_mem = mem_val(mem_addr);
    assign mips_alu = 32'h1234_5678;

    debug_ctrl #(.MAX_CYCLES(MAXC)) u_dut (
        .i_clk                      (clk),
        .i_reset                    (rst),
        .i_uart_rx_ready            (rx_ready),
        .i_uart_rx_data             (rx_data),
        .i_uart_tx_done             (tx_done | spur_done),
        .i_mips_pc                  (pc_q),
        .i_mips_register            (mips_reg),
        .i_mips_mem_data            (mips_mem),
        .i_mips_alu_result          (mips_alu),
        .i_mips_wb_halt             (wb_halt),
        .o_mips_register_number     (reg_num),
        .o_mips_memory_address      (mem_addr),
        .o_uart_tx_data             (tx_data),
        .o_uart_tx_ready            (tx_ready),
        .o_uart_rx_reset            (rx_reset),
        .o_step                     (step),
        .o_instruction_write_enable (we),
        .o_instruction_address      (iaddr),
        .o_instruction_data         (idata),
        .o_status                   (status),
        .o_state_debug              (state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // MIPS model: PC advances by 4 on every enabled clock
    always @(posedge clk) begin
        if (rst) begin
            pc_q  <= 32'h0;
            steps <= 0;
        end else if (step) begin
            pc_q  <= pc_q + 32'd4;
            steps <= steps + 1;
        end
    end

    // Instruction-write scoreboard and rx-reset pulse counter
    always @(negedge clk) begin
        if (rx_reset) rxr_cnt++;
        if (we) begin
            check("wr_pending", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) check("wr_addr_data", {iaddr, idata}, wq.pop_front());
        end
    end

    // UART TX responder: checks each byte, acks it two cycles later
    initial begin
        logic [7:0] exp;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_ready) begin
                check("tx_pending", 64'(txq.size() != 0), 64'd1);
                if (txq.size() != 0) begin
                    exp = txq.pop_front();
                    check("tx_byte", 64'(tx_data), 64'(exp));
                end
                tx_bytes++;
                repeat (2) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) txq.push_back(w[b*8 +: 8]);
    endtask

    task automatic push_frame(input logic [31:0] pcv, input logic [31:0] cnt, input logic [7:0] st);
        txq.push_back(8'hA5);
        push_word(pcv);
        for (int k = 0; k < 32; k++) push_word(reg_val(5'(k)));
        push_word(32'h1234_5678);
        for (int i = 0; i < 16; i++) push_word(mem_val(32'(4 * i)));
        push_word(cnt);
        txq.push_back(st);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
    endtask

    task automatic wait_frame(input string tag);
        int unsigned n = 0;
        while ((txq.size() != 0 || state != 4'd0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_complete"}, 64'(n < 4000), 64'd1);
        check({tag, "_reg_sel0"}, 64'(reg_num), 64'd0);
        check({tag, "_mem_sel0"}, 64'(mem_addr), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned n;
        int unsigned s0;
        int unsigned r0;
        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h0; spur_done = 1'b0; wb_halt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_state",  64'(state),    64'd0);
        check("rst_ready",  64'(tx_ready), 64'd0);
        check("rst_step",   64'(step),     64'd0);
        check("rst_status", 64'(status),   64'd0);
        check("rst_we",     64'(we),       64'd0);
        check("rst_iaddr",  64'(iaddr),    64'd0);

        // single step from PC 0 -> frame shows PC 4, counter 1
        push_frame(32'h4, 32'd1, 8'h00);
        send_byte(8'h73);
        wait_frame("step");
        check("step_pulses", 64'(steps), 64'd1);

        // breakpoint at 0x10, run, then resume past it until the budget runs out
        do_reset();
        send_byte(8'h62);
        send_word(32'h0000_0010);
        push_frame(32'h10, 32'd4, 8'h02);
        send_byte(8'h63);
        wait_frame("bp_run");
        check("bp_steps",  64'(steps),  64'd4);
        check("bp_status", 64'(status), 64'd2);
        push_frame(32'h50, 32'd20, 8'h04);
        send_byte(8'h63);
        wait_frame("bp_resume");
        check("resume_steps", 64'(steps), 64'd20);
        check("resume_pc",    64'(pc_q),  64'h50);

        // halt reaches writeback during the 7th run cycle
        do_reset();
        push_frame(32'h1C, 32'd7, 8'h01);
        send_byte(8'h63);
        n = 0;
        while (!(steps == 6 && step) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("halt_wait", 64'(n < 200), 64'd1);
        wb_halt = 1'b1;
        @(negedge clk);
        wb_halt = 1'b0;
        wait_frame("halt_run");
        check("halt_steps", 64'(steps), 64'd7);
        push_frame(32'h1C, 32'd7, 8'h01);
        s0 = steps;
        send_byte(8'h73);
        wait_frame("halt_step");
        check("halted_no_step", 64'(steps - s0), 64'd0);

        // program load clears halted and the counter
        r0 = rxr_cnt;
        wq.push_back({32'h0, 32'h2001_0005});
        wq.push_back({32'h4, 32'hFFFF_FFFF});
        send_byte(8'h69);
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        check("load_writes_left", 64'(wq.size()), 64'd0);
        check("load_state",       64'(state),     64'd0);
        check("load_rx_reset",    64'(rxr_cnt - r0), 64'd1);
        check("load_status",      64'(status),    64'd0);
        check("load_next_addr",   64'(iaddr),     64'h8);
        push_frame(32'h20, 32'd1, 8'h00);
        send_byte(8'h73);
        wait_frame("post_load_step");
        check("post_load_steps", 64'(steps), 64'd8);

        // 'x' clears the breakpoint, so the run ends on the cycle budget
        do_reset();
        send_byte(8'h62);
        send_word(32'h0000_0008);
        send_byte(8'h78);
        push_frame(32'h50, 32'd20, 8'h04);
        send_byte(8'h63);
        wait_frame("timeout");
        check("timeout_steps",  64'(steps),  64'd20);
        check("timeout_status", 64'(status), 64'd4);

        // reset in the middle of a frame, then stray tx_done while idle
        do_reset();
        push_frame(32'h4, 32'd1, 8'h00);
        s0 = tx_bytes;
        send_byte(8'h73);
        n = 0;
        while (tx_bytes < s0 + 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midframe_wait", 64'(n < 500), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state",  64'(state),    64'd0);
        check("midrst_ready",  64'(tx_ready), 64'd0);
        check("midrst_status", 64'(status),   64'd0);
        txq.delete();
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (6) @(negedge clk);
        check("stray_done_state", 64'(state),    64'd0);
        check("stray_done_ready", 64'(tx_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 SHALL have parameter NB, 32, MIPS word width; must be a multiple of DATA_BITS.
REQ-002 SHALL have parameter DATA_BITS, 8, UART byte width.
REQ-003 SHALL have parameter NUMBER_REGISTERS, 32, registers dumped per frame.
REQ-004 SHALL have parameter NUMBER_MEM_WORDS, 16, data-memory words dumped per frame (byte addresses 0..4*(N-1)).
REQ-005 SHALL have parameter NUM_BREAKPOINTS, 4, PC breakpoint slots.
REQ-006 SHALL have parameter MAX_CYCLES, 450000, run-mode cycle budget.
REQ-007 SHALL have ports i_clk input 1, clock; i_reset input 1, reset, synchronous and active-high.
REQ-008 SHALL have ports i_uart_rx_ready input 1, received-byte strobe; i_uart_rx_data input DATA_BITS, received byte; i_uart_tx_done input 1, byte-sent strobe.
REQ-009 SHALL have ports i_mips_pc, i_mips_register, i_mips_mem_data, i_mips_alu_result, all input NB, MIPS observation; i_mips_wb_halt input 1, HALT reached writeback.
REQ-010 SHALL have ports o_mips_register_number output clog2(NUMBER_REGISTERS), register select; o_mips_memory_address output NB, memory byte address.
REQ-011 SHALL have ports o_uart_tx_data output DATA_BITS; o_uart_tx_ready output 1; o_uart_rx_reset output 1; o_step output 1, MIPS clock-enable.
REQ-012 SHALL have ports o_instruction_write_enable output 1; o_instruction_address output NB; o_instruction_data output NB.
REQ-013 SHALL have ports o_status output 3, {timeout, bp_hit, halted}; o_state_debug output 4, current FSM state.

Function
REQ-014 SHALL have states IDLE, STEP, RUN, LOAD_RX, LOAD_WR, BP_RX, FETCH, SEND, WAIT_TX.
REQ-015 SHALL accept commands only in IDLE on i_uart_rx_ready: 's'(0x73) -> STEP; 'c'(0x63) -> RUN; 'i'(0x69) -> LOAD_RX; 'b'(0x62) -> BP_RX; 'x'(0x78) clears all breakpoint valid bits, stays IDLE; other bytes are ignored. Bytes arriving outside IDLE/LOAD_RX/BP_RX are dropped.
REQ-016 STEP SHALL assert o_step one cycle unless halted, then go to FETCH.
REQ-017 RUN SHALL assert o_step each cycle. It SHALL exit to FETCH when halted (status.halted), when an enabled slot equals i_mips_pc (status.bp_hit, o_step=0 that cycle), or when the cycle counter reaches MAX_CYCLES (status.timeout). Breakpoints SHALL be ignored on the first RUN cycle so 'c' resumes past a hit.
REQ-018 o_step SHALL never be 1 while halted; halted sets on i_mips_wb_halt and clears only on reset or 'i'.
REQ-019 The cycle counter SHALL be 32-bit, increment on every cycle o_step=1, saturate at 2^32-1, and clear on 'i'.
REQ-020 'i' SHALL pulse o_uart_rx_reset one cycle and zero the address, data buffer and counter. LOAD_RX SHALL shift each byte into o_instruction_data MSB-first. After NB/DATA_BITS bytes, LOAD_WR SHALL assert o_instruction_write_enable one cycle at the current address. The address SHALL increment by 4 the cycle after each write. If the written word equals HALT_INSTRUCTION, the block SHALL return to IDLE after the write.
REQ-021 BP_RX SHALL collect NB/DATA_BITS bytes MSB-first into slot ptr, set its valid bit, advance ptr modulo NUM_BREAKPOINTS (round-robin overwrite), then return to IDLE.
REQ-022 FETCH SHALL emit a frame in this order: header 0xA5; PC; registers 0..NUMBER_REGISTERS-1; ALU result; mem words at addresses 0,4,..; cycle counter; trailer {5'b0,o_status}. Words SHALL be sent MSB byte first. Select outputs SHALL be set one cycle before sampling. Both selects SHALL return to 0 at frame end, then the FSM SHALL go to IDLE.
REQ-023 SEND SHALL drive o_uart_tx_data and raise o_uart_tx_ready. WAIT_TX SHALL hold both until i_uart_tx_done, then drop ready for at least one cycle before the next byte.
REQ-024 An i_uart_tx_done received outside WAIT_TX SHALL be ignored.

Reset
REQ-025 When i_reset=1 at a clock edge, the block SHALL go to IDLE. It SHALL zero all outputs, counters, breakpoints, ptr, status and halted, regardless of the state in progress, including mid-frame or mid-load.

Verification
REQ-026 's' with PC=0x4, all regs=0 -> one o_step pulse. TX sequence: A5; 00 00 00 04; 128 zero bytes; ALU word; 64 mem bytes; counter 00 00 00 01; trailer 00.
REQ-027 'i' then bytes 20 01 00 05, FF FF FF FF (HALT_INSTRUCTION assumed 0xFFFFFFFF in bench) -> two writes: addr 0 data 0x20010005, addr 4 data 0xFFFFFFFF; then IDLE.
REQ-028 'b' 00 00 00 10, 'c', with PC advancing by 4 per step -> o_step stops when PC=0x10. Trailer is 0x02. A second 'c' steps past 0x10.
REQ-029 'c' with i_mips_wb_halt at cycle 7 -> trailer 0x01 and counter 7. A following 's' gives no o_step pulse.
REQ-030 MAX_CYCLES=20, 'c', no halt -> exactly 20 o_step pulses, trailer 0x04. i_reset asserted mid-frame -> next cycle IDLE with o_uart_tx_ready=0.
